// File: rtl/shift_pkg.sv
// Shared types and helpers for the shift request arbiter.
package shift_pkg;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        SRA = 2'b10,
        ROL = 2'b11
    } shift_op_t;

    localparam int NREQ = 2;

    function automatic int amt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/barrel_shift_core.sv
// Combinational log-stage barrel shifter: SLL, SRL, SRA and ROL.
module barrel_shift_core
    import shift_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int AMT_W = amt_w(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] amt,
    input  shift_op_t        op,
    output logic [WIDTH-1:0] result
);

    logic [AMT_W:0][WIDTH-1:0] stg;

    // Stage s shifts by 2**s when amt[s] is set.
    always_comb begin
        stg[0] = data;
        for (int s = 0; s < AMT_W; s++) begin
            stg[s+1] = stg[s];
            if (amt[s]) begin
                unique case (op)
                    SLL: stg[s+1] = stg[s] << (1 << s);
                    SRL: stg[s+1] = stg[s] >> (1 << s);
                    SRA: stg[s+1] = $signed(stg[s]) >>> (1 << s);
                    ROL: stg[s+1] = (stg[s] << (1 << s))
                                  | (stg[s] >> (WIDTH - (1 << s)));
                endcase
            end
        end
    end

    assign result = stg[AMT_W];

endmodule

// File: rtl/shift_req_arbiter.sv
// Two-requester round-robin front end sharing one barrel shifter.
// Optional saturating grant counters when SHIFT_STATS_EN is defined.
module shift_req_arbiter
    import shift_pkg::*;
#(
    parameter int WIDTH = 4,
`ifdef SHIFT_STATS_EN
    parameter int CNT_W = 8,
`endif
    localparam int AMT_W = amt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    input  logic [1:0]       req1_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    output logic             idle
`ifdef SHIFT_STATS_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_id_q;
    logic             last_gnt_q;

    logic             can_accept;
    logic [NREQ-1:0]  grant;
    logic             accept;
    logic             sel;
    logic [WIDTH-1:0] sh_data;
    logic [AMT_W-1:0] sh_amt;
    shift_op_t        sh_op;
    logic [WIDTH-1:0] sh_res;

    assign can_accept = !out_valid_q | out_ready;

    // On a tie the pointer picks the requester not granted last.
    always_comb begin
        grant = '0;
        if (!rst && can_accept) begin
            unique case (1'b1)
                (req_valid == 2'b11): grant = last_gnt_q ? 2'b01 : 2'b10;
                default:              grant = req_valid;
            endcase
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;
    assign sel       = grant[1];

    assign sh_data = sel ? req1_data : req0_data;
    assign sh_amt  = sel ? req1_amt  : req0_amt;
    assign sh_op   = shift_op_t'(sel ? req1_op : req0_op);

    barrel_shift_core #(.WIDTH(WIDTH)) u_core (
        .data   (sh_data),
        .amt    (sh_amt),
        .op     (sh_op),
        .result (sh_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= 1'b0;
            last_gnt_q  <= 1'b1;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sh_res;
            out_id_q    <= sel;
            last_gnt_q  <= sel;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign idle      = !out_valid_q && (req_valid == '0);

`ifdef SHIFT_STATS_EN
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (grant[0] && cnt0_q != '1) cnt0_q <= cnt0_q + 1'b1;
            if (grant[1] && cnt1_q != '1) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_shift_req_arbiter.sv
// Directed self-checking bench for shift_req_arbiter (WIDTH=4).
module tb_shift_req_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req0_data;
    logic [1:0] req0_amt;
    logic [1:0] req0_op;
    logic [3:0] req1_data;
    logic [1:0] req1_amt;
    logic [1:0] req1_op;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_id;
    logic       idle;
`ifdef SHIFT_STATS_EN
    logic [7:0] grant_cnt0;
    logic [7:0] grant_cnt1;
`endif

    int errors = 0;
    int checks = 0;

    shift_req_arbiter #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_data (req0_data),
        .req0_amt  (req0_amt),
        .req0_op   (req0_op),
        .req1_data (req1_data),
        .req1_amt  (req1_amt),
        .req1_op   (req1_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .idle      (idle)
`ifdef SHIFT_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL rst_ready: got %b want 00", req_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'b0000 || out_id !== 1'b0) begin
            errors++;
            $display("FAIL rst_out: got v=%b d=%b id=%b want 0 0000 0",
                     out_valid, out_data, out_id);
        end
        req_valid = 2'b00;
        rst = 1'b0;
        #1;
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL rst_idle: got %b want 1", idle);
        end
    endtask

    task automatic test_ops();
        logic [3:0] vd [8] = '{4'b1011, 4'b1000, 4'b1011, 4'b1011,
                               4'b1011, 4'b1011, 4'b1011, 4'b1011};
        logic [1:0] va [8] = '{2'd1, 2'd3, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        logic [1:0] vo [8] = '{2'b00, 2'b01, 2'b10, 2'b11,
                               2'b00, 2'b01, 2'b10, 2'b11};
        logic [3:0] ve [8] = '{4'b0110, 4'b0001, 4'b1110, 4'b1101,
                               4'b1011, 4'b1011, 4'b1011, 4'b1011};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_valid = 2'b01;
            req0_data = vd[i];
            req0_amt  = va[i];
            req0_op   = vo[i];
            #1;
            checks++;
            if (req_ready !== 2'b01) begin
                errors++;
                $display("FAIL op%0d_ready: got %b want 01", i, req_ready);
            end
            step();
            req_valid = 2'b00;
            checks++;
            if (out_valid !== 1'b1 || out_data !== ve[i] || out_id !== 1'b0) begin
                errors++;
                $display("FAIL op%0d_result: got v=%b d=%b id=%b want 1 %b 0",
                         i, out_valid, out_data, out_id, ve[i]);
            end
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL op_drain: got v=%b idle=%b want 0 1", out_valid, idle);
        end
    endtask

    task automatic test_tie();
        logic [1:0] er [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic       ei [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [3:0] ed [4] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        req0_data = 4'b0001; req0_amt = 2'd0; req0_op = 2'b00;
        req1_data = 4'b0100; req1_amt = 2'd1; req1_op = 2'b01;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (req_ready !== er[i]) begin
                errors++;
                $display("FAIL tie%0d_ready: got %b want %b", i, req_ready, er[i]);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_id !== ei[i] || out_data !== ed[i]) begin
                errors++;
                $display("FAIL tie%0d_out: got v=%b id=%b d=%b want 1 %b %b",
                         i, out_valid, out_id, out_data, ei[i], ed[i]);
            end
        end
        req_valid = 2'b00;
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        req_valid = 2'b01;
        req0_data = 4'b1011; req0_amt = 2'd1; req0_op = 2'b00;
        step();
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (req_ready !== 2'b00 || out_valid !== 1'b1 || out_data !== 4'b0110) begin
                errors++;
                $display("FAIL bp%0d: got rdy=%b v=%b d=%b want 00 1 0110",
                         i, req_ready, out_valid, out_data);
            end
            step();
        end
        req_valid = 2'b10;
        req1_data = 4'b1000; req1_amt = 2'd3; req1_op = 2'b01;
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL bp_release_ready: got %b want 10", req_ready);
        end
        step();
        req_valid = 2'b00;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b0001 || out_id !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_out: got v=%b d=%b id=%b want 1 0001 1",
                     out_valid, out_data, out_id);
        end
    endtask

    task automatic test_single();
        req_valid = 2'b10;
        req1_data = 4'b0101; req1_amt = 2'd1; req1_op = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL single_ready: got %b want 10", req_ready);
        end
        step();
        req_valid = 2'b00;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b1010 || out_id !== 1'b1) begin
            errors++;
            $display("FAIL single_out: got v=%b d=%b id=%b want 1 1010 1",
                     out_valid, out_data, out_id);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        req_valid = 2'b11;
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL rmid_ready: got %b want 00", req_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL rmid_out: got v=%b rdy=%b want 0 00", out_valid, req_ready);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        req0_data = 4'b0011; req0_amt = 2'd2; req0_op = 2'b00;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rmid_tie_ready: got %b want 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        checks++;
        if (out_valid !== 1'b1 || out_id !== 1'b0 || out_data !== 4'b1100) begin
            errors++;
            $display("FAIL rmid_tie_out: got v=%b id=%b d=%b want 1 0 1100",
                     out_valid, out_id, out_data);
        end
        step();
    endtask

`ifdef SHIFT_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        req_valid = 2'b01;
        req0_data = 4'b0001; req0_amt = 2'd0; req0_op = 2'b00;
        repeat (300) step();
        req_valid = 2'b00;
        checks++;
        if (grant_cnt0 !== 8'd255 || grant_cnt1 !== 8'd0) begin
            errors++;
            $display("FAIL stats_sat: got c0=%0d c1=%0d want 255 0",
                     grant_cnt0, grant_cnt1);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (grant_cnt0 !== 8'd0 || grant_cnt1 !== 8'd0) begin
            errors++;
            $display("FAIL stats_rst: got c0=%0d c1=%0d want 0 0",
                     grant_cnt0, grant_cnt1);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        out_ready = 1'b0;
        req0_data = '0; req0_amt = '0; req0_op = '0;
        req1_data = '0; req1_amt = '0; req1_op = '0;
        step();
        test_reset();
        test_ops();
        test_tie();
        test_back_to_back();
        test_single();
        test_reset_mid();
`ifdef SHIFT_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
